// File: rtl/div_pkg.sv
// Shared encodings for the restoring-division controller and its datapath.
package div_pkg;

  // Default number of quotient bits, which is also the number of iterations.
  localparam int NBITS_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SUB    = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Datapath remainder-mux selects. 2'b00 is never driven.
  localparam logic [1:0] SEL_ADD  = 2'b01;  // adder result into upper half
  localparam logic [1:0] SEL_LOAD = 2'b10;  // {0, dividend}
  localparam logic [1:0] SEL_HOLD = 2'b11;  // keep current remainder

endpackage

// File: rtl/divider_control.sv
// Sequencing FSM for the 8-bit / 7-bit restoring divider: one load cycle,
// then NBITS subtract/decide pairs, then a one-cycle done pulse.
module divider_control
  import div_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic       start,
  input  logic [6:0] divisorin,
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  localparam int CW = $clog2(NBITS) + 1;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic            r_dbz;
  logic            w_accept;
  logic            w_last;

  // A start is only honoured from IDLE; anywhere else it is dropped.
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_count == CW'(NBITS - 1));
  assign dbz      = r_dbz;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Iteration counter and divide-by-zero flag, both captured on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_dbz   <= (divisorin == 7'd0);
    end else if (r_state == ST_DECIDE) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = start ? ST_SUB : ST_IDLE;
      ST_SUB:    w_next = ST_DECIDE;
      ST_DECIDE: w_next = w_last ? ST_DONE : ST_SUB;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath controls; reset overrides everything, including the Mealy start path.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    sel   = SEL_HOLD;
    busy  = 1'b0;
    done  = 1'b0;
    if (!reset) begin
      sel = SEL_HOLD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Capture divisor and {0, dividend} already shifted left once.
            load  = 1'b1;
            sel   = SEL_LOAD;
            shift = 1'b1;
            inbit = 1'b0;
          end else begin
            sel = SEL_HOLD;
          end
        end
        ST_SUB: begin
          sel  = SEL_ADD;
          add  = 1'b0;
          busy = 1'b1;
        end
        ST_DECIDE: begin
          busy  = 1'b1;
          shift = 1'b1;
          if (sign) begin
            // Negative difference: restore and shift in a 0 in the same cycle.
            sel   = SEL_ADD;
            add   = 1'b1;
            inbit = 1'b0;
          end else begin
            // Non-negative: keep the difference, shift in a 1.
            sel   = SEL_HOLD;
            inbit = 1'b1;
          end
        end
        ST_DONE: begin
          done = 1'b1;
        end
        default: begin
          sel = SEL_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_control.sv
// Self-checking bench for divider_control with a behavioural datapath attached.
module tb_divider_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] divisorin;
  logic       sign;
  logic       load, add, shift, inbit, busy, done, dbz;
  logic [1:0] sel;

  // Datapath model state
  logic [7:0]  tb_dividend;
  logic [15:0] r_rem;
  logic [6:0]  r_dvs;
  logic [15:0] nxt;
  logic [7:0]  alu;

  int n_checks = 0;
  int n_fail   = 0;

  divider_control #(.NBITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .divisorin(divisorin), .sign(sign),
    .load(load), .add(add), .shift(shift), .inbit(inbit), .sel(sel),
    .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  assign sign = r_rem[15];

  // Restoring-division datapath driven by the controller outputs
  always @(posedge clk) begin
    alu = add ? (r_rem[15:8] + {1'b0, r_dvs}) : (r_rem[15:8] - {1'b0, r_dvs});
    nxt = r_rem;
    case (sel)
      2'b01:   nxt[15:8] = alu;
      2'b10:   nxt = {8'h00, tb_dividend};
      default: nxt = r_rem;
    endcase
    if (shift) nxt = {nxt[14:0], inbit};
    r_rem <= nxt;
    if (load) r_dvs <= divisorin;
  end

  function automatic logic [7:0] outs();
    return {load, add, shift, inbit, sel, busy, done};
  endfunction

  // One full division. start is high in cycles c < hold and in cycle c == pulse.
  task automatic do_div(input logic [7:0] dvd, input logic [6:0] dvs,
                        input int hold, input int pulse, input string nm);
    logic [7:0] q, r, exp;
    if (dvs == 7'd0) begin q = 8'hFF; r = 8'h00; end
    else begin q = 8'(dvd / dvs); r = 8'(dvd % dvs); end
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tb_dividend = dvd;
        divisorin   = dvs;
        start       = 1'b1;
      end else begin
        divisorin = 7'($urandom);
        start     = (c < hold) || (c == pulse);
      end
      #1;
      if (c == 0)       exp = {1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
      else if (c == 17) exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1};
      else if (c % 2 == 1) exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
      else if (q[7 - (c / 2 - 1)]) exp = {1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
      else exp = {1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL %s ctrl cycle %0d: got %b want %b (ld,add,sh,in,sel,busy,done)",
                 nm, c, outs(), exp);
      end
      if (c == 1 || c == 17) begin
        n_checks++;
        if (dbz !== (dvs == 7'd0)) begin
          n_fail++;
          $display("FAIL %s dbz cycle %0d: got %b want %b", nm, c, dbz, (dvs == 7'd0));
        end
      end
      if (c == 17) begin
        n_checks++;
        if ({r_rem[7:0], 1'b0, r_rem[15:9]} !== {q, r}) begin
          n_fail++;
          $display("FAIL %s result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                   nm, dvd, dvs, r_rem[7:0], r_rem[15:9], q, r);
        end
      end
    end
  endtask

  task automatic idle_check(input string nm, input logic exp_dbz);
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++;
    if ({outs(), dbz} !== {8'b0000_1100, exp_dbz}) begin
      n_fail++;
      $display("FAIL %s idle: got %b want %b", nm, {outs(), dbz}, {8'b0000_1100, exp_dbz});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; divisorin = 7'd0; tb_dividend = 8'd0;
    r_rem = 16'h0; r_dvs = 7'd0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({outs(), dbz} !== 9'b0000_1100_0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want %b", {outs(), dbz}, 9'b0000_1100_0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_check("after_reset", 1'b0);
  endtask

  task automatic test_basic();
    do_div(8'd100, 7'd7, 1, -1, "100/7");
    idle_check("post_100/7", 1'b0);
    do_div(8'd255, 7'd1, 1, -1, "255/1");
    do_div(8'd5, 7'd127, 1, -1, "5/127");
  endtask

  task automatic test_dbz();
    do_div(8'd0, 7'd0, 1, -1, "0/0");
    for (int i = 0; i < 3; i++) idle_check("dbz_hold", 1'b1);
    do_div(8'd9, 7'd3, 1, -1, "9/3");
  endtask

  task automatic test_back_to_back();
    // start high for 18 + 2 = 20 cycles: second division accepted at cycle 18
    do_div(8'd200, 7'd13, 100, -1, "hold_first");
    do_div(8'd77, 7'd5, 2, -1, "hold_second");
    idle_check("post_hold", 1'b0);
    do_div(8'd123, 7'd10, 1, 5, "pulse_mid");
    idle_check("post_pulse", 1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    tb_dividend = 8'd50; divisorin = 7'd0; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    n_checks++;
    if ({busy, dbz} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_reset pre: got busy,dbz=%b want 11", {busy, dbz});
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    #1;
    n_checks++;
    if ({outs(), dbz} !== 9'b0000_1100_0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got %b want %b", {outs(), dbz}, 9'b0000_1100_0);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_div(8'd100, 7'd7, 1, -1, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      logic [6:0] b;
      a = 8'($urandom);
      b = 7'($urandom_range(127, 1));
      do_div(a, b, 1, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
